inst_buffer: RTL and testbench
==============================

INST_BUFFER -- requirements
Module: inst_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, log2 of entry count (DEPTH = 16), equal to `IB_WIDTH_LOG2.
REQ-002 SHALL have parameter DATA_WD, default 66, entry width {pc_valid, pc_is_jump, pc[31:0], inst[31:0]}, equal to `IB_DATA_BUS_WD.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 flush_IB  input  1  synchronous clear of all entries (pipeline redirect).
REQ-006 if1_to_ib  input  4 x DATA_WD  push slots 0..3; slot 0 is oldest.
REQ-007 push_num  input  3  number of slots to push this cycle (0..4); values 5..7 treated as 0.
REQ-008 can_push_size  output  DEPTH_LOG2+1  current occupancy count (0..DEPTH), registered.
REQ-009 ib_to_id  output  2 x DATA_WD  two oldest entries; slot 0 is head.
REQ-010 ib_valid  output  2  ib_valid[k] = 1 iff slot k holds a live entry.
REQ-011 pop_num  input  2  number of entries decode consumes this cycle (0..2; 3 treated as 2).

Function
REQ-012 Storage: circular array of DEPTH entries, head pointer, tail pointer (DEPTH_LOG2 bits each, wrap modulo DEPTH), count register (DEPTH_LOG2+1 bits).
REQ-013 Push accepted iff push_num in 1..4 and count + push_num <= DEPTH, using count before this cycle's pop; otherwise the entire push is dropped (no partial push).
REQ-014 Accepted push: slot i (i < push_num) written to entry (tail + i) mod DEPTH; tail advances by push_num modulo DEPTH.
REQ-015 Effective pop = min(pop_num, count) evaluated on pre-edge count; head advances by effective pop modulo DEPTH.
REQ-016 count_next = count + accepted push - effective pop; same-cycle push and pop both apply.
REQ-017 ib_to_id[k] = entry (head + k) mod DEPTH, combinational from storage; ib_valid[0] = (count >= 1), ib_valid[1] = (count >= 2).
REQ-018 No bypass: data pushed in cycle N first visible on ib_to_id in cycle N+1.
REQ-019 ib_to_id content when ib_valid[k] = 0 is don't-care; verification checks only valid slots.
REQ-020 can_push_size = count; upstream rule "push only when can_push_size + n < 2^DEPTH_LOG2" always satisfies REQ-013.
REQ-021 Wrap-around: pushes and pops spanning index DEPTH-1 -> 0 preserve strict FIFO order.
REQ-022 flush_IB = 1: at the next edge head, tail, count <= 0; any push or pop in that cycle is ignored; flush wins over all.
REQ-023 Entry storage has no reset; only pointers and count are reset.

Reset
REQ-024 resetn low asynchronously forces head = 0, tail = 0, count = 0, so can_push_size = 0 and ib_valid = 2'b00 immediately, independent of clk.
REQ-025 resetn asserted mid-push/pop discards that operation; first push after resetn rises lands in entry 0.
REQ-026 Deassertion is synchronized externally; the block requires no extra cycles after release.

Verification
REQ-027 Reset, push_num=4 with pcs 0x1c000000..0x1c00000c -> next cycle can_push_size=4, ib_valid=2'b11, ib_to_id[0].pc=0x1c000000, ib_to_id[1].pc=0x1c000004.
REQ-028 count=14, push_num=3, pop_num=0 -> push dropped, count stays 14; same with push_num=2 -> count=16.
REQ-029 count=3, push_num=2 and pop_num=2 same cycle -> count=3, head advances 2, new entries appear behind the remaining one in order.
REQ-030 head=tail=14 (count 0), push 4 entries, then pop 2 per cycle for 2 cycles -> pcs emerge in push order across 15->0 wrap, final count=0, ib_valid=2'b00.
REQ-031 count=1, pop_num=2 -> effective pop 1, count=0, no underflow; count=5, flush_IB=1 with push_num=4 -> next cycle count=0, ib_valid=2'b00.
REQ-032 count=9, resetn pulsed low between edges -> can_push_size=0 and ib_valid=2'b00 before the next rising edge.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction buffer between fetch (up to 4 pushes per cycle) and decode (up to 2 pops per cycle).
// Circular store of DEPTH entries with head/tail pointers and an occupancy count.
module inst_buffer #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_WD    = 66
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    flush_IB,
    input  logic [4*DATA_WD-1:0]    if1_to_ib,
    input  logic [2:0]              push_num,
    output logic [DEPTH_LOG2:0]     can_push_size,
    output logic [2*DATA_WD-1:0]    ib_to_id,
    output logic [1:0]              ib_valid,
    input  logic [1:0]              pop_num
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WD-1:0]    mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] head_q, head_d;
    logic [DEPTH_LOG2-1:0] tail_q, tail_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;

    logic [2:0]            push_req;
    logic [DEPTH_LOG2+1:0] push_sum;
    logic                  push_ok;
    logic [2:0]            push_amt;
    logic [1:0]            pop_req;
    logic [1:0]            pop_amt;
    logic                  wr_en;

    // Push/pop contract: fetch offers push_num slots and the whole group is taken
    // only if it fits in the pre-edge occupancy; otherwise nothing is stored.
    // Decode takes pop_num entries, clipped to what is live. Both apply at the edge.
    always_comb begin
        push_req = (push_num > 3'd4) ? 3'd0 : push_num;
        push_sum = (DEPTH_LOG2+2)'(count_q) + (DEPTH_LOG2+2)'(push_req);
        push_ok  = (push_req != 3'd0) && (push_sum <= (DEPTH_LOG2+2)'(DEPTH));
        push_amt = push_ok ? push_req : 3'd0;
        pop_req  = (pop_num == 2'd3) ? 2'd2 : pop_num;
        pop_amt  = (count_q < (DEPTH_LOG2+1)'(pop_req)) ? count_q[1:0] : pop_req;
        wr_en    = push_ok && !flush_IB;

        head_d   = head_q + DEPTH_LOG2'(pop_amt);
        tail_d   = tail_q + DEPTH_LOG2'(push_amt);
        count_d  = count_q + (DEPTH_LOG2+1)'(push_amt) - (DEPTH_LOG2+1)'(pop_amt);
        if (flush_IB) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; stale contents are masked by the count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && (i < int'(push_amt))) begin
                mem_q[tail_q + DEPTH_LOG2'(i)] <= if1_to_ib[i*DATA_WD +: DATA_WD];
            end
        end
    end

    assign ib_to_id[0 +: DATA_WD]       = mem_q[head_q];
    assign ib_to_id[DATA_WD +: DATA_WD] = mem_q[head_q + DEPTH_LOG2'(1)];
    assign ib_valid                     = {(count_q >= (DEPTH_LOG2+1)'(2)),
                                           (count_q >= (DEPTH_LOG2+1)'(1))};
    assign can_push_size                = count_q;

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer: a driver issues push/pop/flush vectors, an expected
// queue holds the live entries in FIFO order, and a negedge monitor compares outputs.
module tb_inst_buffer;

    localparam int W  = 66;
    localparam int DL = 4;

    logic           clk;
    logic           resetn;
    logic           flush_IB;
    logic [4*W-1:0] if1_to_ib;
    logic [2:0]     push_num;
    logic [DL:0]    can_push_size;
    logic [2*W-1:0] ib_to_id;
    logic [1:0]     ib_valid;
    logic [1:0]     pop_num;

    logic [W-1:0] exp_q[$];
    int           vectors;
    int           miscompares;
    logic         mon_en;

    inst_buffer #(.DEPTH_LOG2(DL), .DATA_WD(W)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush_IB      (flush_IB),
        .if1_to_ib     (if1_to_ib),
        .push_num      (push_num),
        .can_push_size (can_push_size),
        .ib_to_id      (ib_to_id),
        .ib_valid      (ib_valid),
        .pop_num       (pop_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mk(input logic [31:0] pc);
        return {1'b1, 1'b0, pc, pc ^ 32'h0000_0013};
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_slots(input logic [31:0] base);
        for (int i = 0; i < 4; i++) if1_to_ib[i*W +: W] = mk(base + 32'(4*i));
    endtask

    // Drive one cycle of stimulus and record the expected FIFO contents after the edge.
    task automatic step(input int pn, input int popn, input logic fl);
        int cnt;
        int eff_pop;
        push_num = pn[2:0];
        pop_num  = popn[1:0];
        flush_IB = fl;
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            cnt     = exp_q.size();
            eff_pop = (popn == 3) ? 2 : popn;
            if (eff_pop > cnt) eff_pop = cnt;
            if (pn >= 1 && pn <= 4 && cnt + pn <= 16)
                for (int i = 0; i < pn; i++) exp_q.push_back(if1_to_ib[i*W +: W]);
            for (int i = 0; i < eff_pop; i++) void'(exp_q.pop_front());
        end
        #1;
        push_num = 3'd0;
        pop_num  = 2'd0;
        flush_IB = 1'b0;
    endtask

    function automatic logic [31:0] pc_of(input int k);
        logic [W-1:0] e;
        e = ib_to_id[k*W +: W];
        return e[63:32];
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("count", W'(can_push_size), W'(exp_q.size()));
            chk("valid", W'(ib_valid), W'({exp_q.size() >= 2, exp_q.size() >= 1}));
            if (exp_q.size() >= 1) chk("slot0", ib_to_id[0 +: W], exp_q[0]);
            if (exp_q.size() >= 2) chk("slot1", ib_to_id[W +: W], exp_q[1]);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        mon_en      = 1'b0;
        resetn      = 1'b1;
        flush_IB    = 1'b0;
        push_num    = 3'd0;
        pop_num     = 2'd0;
        if1_to_ib   = '0;
        #2 resetn = 1'b0;
        #1;
        chk("rst_count", W'(can_push_size), W'(0));
        chk("rst_valid", W'(ib_valid), W'(2'b00));
        @(posedge clk);
        #1 resetn = 1'b1;
        mon_en = 1'b1;

        // Four pushes after reset
        set_slots(32'h1c00_0000);
        step(4, 0, 1'b0);
        chk("p4_count", W'(can_push_size), W'(4));
        chk("p4_valid", W'(ib_valid), W'(2'b11));
        chk("p4_pc0", W'(pc_of(0)), W'(32'h1c00_0000));
        chk("p4_pc1", W'(pc_of(1)), W'(32'h1c00_0004));
        step(0, 2, 1'b0);
        step(0, 2, 1'b0);
        chk("drain_count", W'(can_push_size), W'(0));

        // Simultaneous push 2 / pop 2 with count 3
        set_slots(32'h0000_0100);
        step(3, 0, 1'b0);
        set_slots(32'h0000_0200);
        step(2, 2, 1'b0);
        chk("pp_count", W'(can_push_size), W'(3));
        chk("pp_pc0", W'(pc_of(0)), W'(32'h0000_0108));
        chk("pp_pc1", W'(pc_of(1)), W'(32'h0000_0200));
        step(0, 2, 1'b0);
        step(0, 2, 1'b0);
        chk("underflow_count", W'(can_push_size), W'(0));

        // Move head=tail to 14, then push across the 15->0 wrap
        set_slots(32'h0000_0300);
        step(4, 0, 1'b0);
        step(1, 0, 1'b0);
        step(0, 2, 1'b0);
        step(0, 2, 1'b0);
        step(0, 2, 1'b0);
        chk("pre_wrap_count", W'(can_push_size), W'(0));
        set_slots(32'h1c00_1000);
        step(4, 0, 1'b0);
        chk("wrap_pc0", W'(pc_of(0)), W'(32'h1c00_1000));
        step(0, 2, 1'b0);
        chk("wrap_pc0b", W'(pc_of(0)), W'(32'h1c00_1008));
        chk("wrap_pc1b", W'(pc_of(1)), W'(32'h1c00_100c));
        step(0, 2, 1'b0);
        chk("wrap_count", W'(can_push_size), W'(0));
        chk("wrap_valid", W'(ib_valid), W'(2'b00));

        // Fill to 14, reject an overflowing push, then fill exactly to 16
        for (int i = 0; i < 3; i++) begin
            set_slots(32'h0000_4000 + 32'(i * 16));
            step(4, 0, 1'b0);
        end
        set_slots(32'h0000_5000);
        step(2, 0, 1'b0);
        chk("fill14", W'(can_push_size), W'(14));
        set_slots(32'h0000_6000);
        step(3, 0, 1'b0);
        chk("drop14", W'(can_push_size), W'(14));
        set_slots(32'h0000_7000);
        step(2, 0, 1'b0);
        chk("full16", W'(can_push_size), W'(16));
        set_slots(32'h0000_8000);
        step(1, 1, 1'b0);
        chk("full_pop", W'(can_push_size), W'(15));

        // Down to 5, then flush with a push and pop pending
        for (int i = 0; i < 5; i++) step(0, 2, 1'b0);
        chk("five", W'(can_push_size), W'(5));
        set_slots(32'h0000_9000);
        step(4, 2, 1'b1);
        chk("flush_count", W'(can_push_size), W'(0));
        chk("flush_valid", W'(ib_valid), W'(2'b00));

        // push_num 5 ignored, pop_num 3 acts as 2
        set_slots(32'h0000_a000);
        step(3, 0, 1'b0);
        set_slots(32'h0000_b000);
        step(5, 3, 1'b0);
        chk("odd_codes", W'(can_push_size), W'(1));
        chk("odd_pc0", W'(pc_of(0)), W'(32'h0000_a008));

        // Asynchronous reset between edges with count 9
        set_slots(32'h0000_c000);
        step(4, 0, 1'b0);
        step(4, 0, 1'b0);
        chk("nine", W'(can_push_size), W'(9));
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_count", W'(can_push_size), W'(0));
        chk("async_valid", W'(ib_valid), W'(2'b00));
        exp_q.delete();
        @(posedge clk);
        #1 resetn = 1'b1;
        set_slots(32'h0000_d000);
        step(2, 0, 1'b0);
        chk("post_rst_count", W'(can_push_size), W'(2));
        chk("post_rst_pc0", W'(pc_of(0)), W'(32'h0000_d000));
        chk("post_rst_pc1", W'(pc_of(1)), W'(32'h0000_d004));
        @(negedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
